tile_window_fetcher: RTL and testbench
======================================

// Module: tile_window_fetcher
// PURPOSE
//  Generates overlapping WIN_ROWS x WIN_COLS pixel tiles from a frame in row-addressed memory.
//  Tiles are emitted in raster order (stride OUT_ROWS rows, OUT_COLS cols) on a valid/ready port.
//  Sits between frame memory and the median-filter core.
//  Parametrised successor of the fixed 5x14 / stride 3x12 hand-fed stimulus. Adds backpressure, a
//  tile-position sideband and optional edge clamping.
// PARAMETERS
//  PIX_W      8    bits per pixel
//  IMG_W      638  frame width (pixels)
//  IMG_H      482  frame height (rows)
//  WIN_ROWS   5    tile height (rows fetched per tile)
//  WIN_COLS   14   tile width (pixels per memory read)
//  OUT_ROWS   3    vertical stride; 1 <= OUT_ROWS <= WIN_ROWS
//  OUT_COLS   12   horizontal stride; 1 <= OUT_COLS <= WIN_COLS
//  EDGE_MODE  0    0 = drop incomplete edge tiles; 1 = add one clamped tile at IMG_W-WIN_COLS / IMG_H-WIN_ROWS
// PORTS
//  clk        in   1                     clock, rising edge
//  rst        in   1                     synchronous, active-high reset
//  start      in   1                     begin frame; sampled only in IDLE
//  busy       out  1                     high from accepted start until done
//  done       out  1                     1-cycle pulse after last tile handshake
//  mem_rd     out  1                     read strobe
//  mem_row    out  clog2(IMG_H)          row address
//  mem_col    out  clog2(IMG_W)          leftmost column of the read
//  mem_rdata  in   WIN_COLS*PIX_W        pixels mem_col..mem_col+WIN_COLS-1, leftmost in MSBs; valid cycle after mem_rd
//  tile_valid out  1                     tile_data holds a complete tile
//  tile_ready in   1                     consumer accepts the tile on valid&ready
//  tile_data  out  WIN_ROWS*WIN_COLS*PIX_W  row 0 in MSBs; rows concatenated top to bottom
//  tile_row   out  clog2(IMG_H)          top row of the current tile
//  tile_col   out  clog2(IMG_W)          left column of the current tile
//  tile_last  out  1                     qualifies the final tile of the frame
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; row/col counters 0; in-flight mem_rdata discarded.
//  Reset mid-frame aborts the frame: no done pulse.
//  FSM:
//   IDLE  -> FETCH on start.
//   FETCH: WIN_ROWS cycles; mem_rd=1, mem_row=tile_row+k (k=0..WIN_ROWS-1), mem_col=tile_col.
//   WAIT: 1 cycle; captures the last row.
//   OUT: tile_valid=1 until tile_ready.
//    On handshake: last tile -> DONE; otherwise advance and re-enter FETCH next cycle.
//   DONE: done=1, busy=0, 1 cycle -> IDLE.
//  Latency: start at edge t -> mem_rd during t+1..t+WIN_ROWS.
//   Row k is captured one cycle after its read.
//   tile_valid rises at t+WIN_ROWS+2.
//  Throughput: one tile per WIN_ROWS+2 cycles when tile_ready is held high. No overlap of fetch and output.
//  Advance order: col += OUT_COLS while col+OUT_COLS+WIN_COLS <= IMG_W.
//   Otherwise col=0 and row += OUT_ROWS while row+OUT_ROWS+WIN_ROWS <= IMG_H.
//   Otherwise the frame is finished.
//  EDGE_MODE=1:
//   If the last normal column start < IMG_W-WIN_COLS, emit one extra tile at col=IMG_W-WIN_COLS.
//   Rows are handled likewise with IMG_H-WIN_ROWS.
//   No duplicate tile when the last normal start already equals the clamp value.
//  tile_data/row/col/last are stable while tile_valid & !tile_ready.
//  tile_last=1 only with the final tile_valid.
//  start while busy: ignored. start in the DONE cycle: ignored.
//  tile_ready outside OUT: no effect.
//  mem_rdata is sampled only in the cycle after mem_rd. The memory has no stall; read latency is exactly 1.
// TESTING
//  T1 default params, ramp frame pix(r,c)=(r*7+c)&255, ready=1
//     -> 53x160=8480 tiles; first tile row0 col0; tile 2 col 12;
//        last tile row477 col624 with tile_last; done 1 cycle after;
//        every tile_data matches the golden slice.
//  T2 default params, tile_ready low 10 cycles on tile 0
//     -> tile_valid held; data/row/col unchanged;
//        tile 1 FETCH starts the cycle after the handshake.
//  T3 IMG_W=40, IMG_H=10
//     -> EDGE_MODE=0: cols {0,12,24}, rows {0,3}, 6 tiles.
//     -> EDGE_MODE=1: cols {0,12,24,26}, rows {0,3,5}, 12 tiles.
//  T4 rst asserted in FETCH of tile 5
//     -> next cycle all outputs 0, no done pulse;
//        a new start begins again at row0 col0.
//  T5 start pulsed again while busy and in the DONE cycle
//     -> ignored; exactly one done per accepted start.
//  T6 start at cycle t, ready=1
//     -> mem_rd at t+1..t+5, tile_valid at t+7, tile 1 tile_valid at t+14.

Source files
------------

// File: rtl/tile_window_fetcher.sv
// Tile window fetcher: walks a frame held in row-addressed memory and emits
// overlapping WIN_ROWS x WIN_COLS tiles in raster order on a valid/ready port,
// with the tile's top-left position as a sideband and optional edge clamping.
module tile_window_fetcher #(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned IMG_W     = 638,
  parameter int unsigned IMG_H     = 482,
  parameter int unsigned WIN_ROWS  = 5,
  parameter int unsigned WIN_COLS  = 14,
  parameter int unsigned OUT_ROWS  = 3,
  parameter int unsigned OUT_COLS  = 12,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_rd,
  output logic [$clog2(IMG_H)-1:0]            mem_row,
  output logic [$clog2(IMG_W)-1:0]            mem_col,
  input  logic [WIN_COLS*PIX_W-1:0]           mem_rdata,
  output logic                                tile_valid,
  input  logic                                tile_ready,
  output logic [WIN_ROWS*WIN_COLS*PIX_W-1:0]  tile_data,
  output logic [$clog2(IMG_H)-1:0]            tile_row,
  output logic [$clog2(IMG_W)-1:0]            tile_col,
  output logic                                tile_last
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned KW = (WIN_ROWS > 1) ? $clog2(WIN_ROWS) : 1;
  localparam int unsigned LW = WIN_COLS * PIX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t                     state;
  state_t                     state_nx;
  logic [KW-1:0]              k;
  logic [RW-1:0]              row;
  logic [CW-1:0]              col;
  logic                       cap_en;
  logic [KW-1:0]              cap_idx;
  // Row 0 of the tile lives in the most significant slot.
  logic [WIN_ROWS-1:0][LW-1:0] line;

  logic col_step;
  logic col_clamp;
  logic row_step;
  logic row_clamp;
  logic last_col;
  logic last_row;

  assign tile_row  = row;
  assign tile_col  = col;
  assign tile_data = line;

  // Next tile position: normal stride first, then one optional clamped edge tile.
  always_comb begin
    col_step  = (32'(col) + OUT_COLS + WIN_COLS <= IMG_W);
    col_clamp = (EDGE_MODE != 0) && !col_step && (32'(col) < IMG_W - WIN_COLS);
    row_step  = (32'(row) + OUT_ROWS + WIN_ROWS <= IMG_H);
    row_clamp = (EDGE_MODE != 0) && !row_step && (32'(row) < IMG_H - WIN_ROWS);
    last_col  = !col_step && !col_clamp;
    last_row  = !row_step && !row_clamp;
  end

  // FSM next-state and output decode.
  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd     = 1'b0;
    mem_row    = '0;
    mem_col    = '0;
    tile_valid = 1'b0;
    tile_last  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy    = 1'b1;
        mem_rd  = 1'b1;
        mem_row = row + RW'(k);
        mem_col = col;
        if (k == KW'(WIN_ROWS - 1)) state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        state_nx = S_OUT;
      end
      S_OUT: begin
        busy       = 1'b1;
        tile_valid = 1'b1;
        tile_last  = last_col && last_row;
        if (tile_ready) state_nx = (last_col && last_row) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, row counter, tile position and read-data capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      k       <= '0;
      row     <= '0;
      col     <= '0;
      cap_en  <= 1'b0;
      cap_idx <= '0;
      line    <= '0;
    end else begin
      state   <= state_nx;
      cap_en  <= mem_rd;
      cap_idx <= k;
      if (cap_en) line[KW'(WIN_ROWS - 1) - cap_idx] <= mem_rdata;
      case (state)
        S_FETCH: k <= (k == KW'(WIN_ROWS - 1)) ? '0 : k + KW'(1);
        S_OUT: begin
          if (tile_ready) begin
            if (col_step) begin
              col <= col + CW'(OUT_COLS);
            end else if (col_clamp) begin
              col <= CW'(IMG_W - WIN_COLS);
            end else if (row_step) begin
              col <= '0;
              row <= row + RW'(OUT_ROWS);
            end else if (row_clamp) begin
              col <= '0;
              row <= RW'(IMG_H - WIN_ROWS);
            end
          end
        end
        S_DONE: begin
          row <= '0;
          col <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_window_fetcher.sv
// Bench for tile_window_fetcher: a default-size instance plus two 40x10 instances
// (edge dropping and edge clamping), each fed by a ramp-image memory model.
module tb_tile_window_fetcher;

  localparam int unsigned LW = 14 * 8;
  localparam int unsigned DW = 5 * LW;

  typedef struct {
    int unsigned hold;
    int unsigned row;
    int unsigned col;
    bit          last;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          st[3];
  logic          rdy[3];
  logic          bz[3];
  logic          dn[3];
  logic          mr[3];
  logic          tv[3];
  logic          tl[3];
  logic [DW-1:0] td[3];
  int unsigned   trow[3];
  int unsigned   tcol[3];
  int unsigned   mrow[3];
  int unsigned   mcol[3];
  int            dcnt[3] = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [LW-1:0] mem_word(input int unsigned r, input int unsigned c);
    logic [LW-1:0] w;
    w = '0;
    for (int unsigned j = 0; j < 14; j++) w[(13 - j) * 8 +: 8] = 8'((r * 7 + c + j) & 255);
    return w;
  endfunction

  function automatic logic [DW-1:0] tile_gold(input int unsigned r, input int unsigned c);
    logic [DW-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < 5; i++) t[(4 - i) * LW +: LW] = mem_word(r + i, c);
    return t;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned IW = (g == 0) ? 638 : 40;
    localparam int unsigned IH = (g == 0) ? 482 : 10;
    localparam int unsigned EM = (g == 2) ? 1 : 0;
    logic                    b, d, m, v, l;
    logic [$clog2(IH)-1:0]   mrw, trw;
    logic [$clog2(IW)-1:0]   mcl, tcl;
    logic [DW-1:0]           dat;
    logic [LW-1:0]           rdata;

    tile_window_fetcher #(.IMG_W(IW), .IMG_H(IH), .EDGE_MODE(EM)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (st[g]),
      .busy       (b),
      .done       (d),
      .mem_rd     (m),
      .mem_row    (mrw),
      .mem_col    (mcl),
      .mem_rdata  (rdata),
      .tile_valid (v),
      .tile_ready (rdy[g]),
      .tile_data  (dat),
      .tile_row   (trw),
      .tile_col   (tcl),
      .tile_last  (l)
    );

    // One-cycle-latency memory; junk on the bus whenever no read was issued.
    always @(posedge clk)
      rdata <= m ? mem_word(32'(mrw), 32'(mcl))
                 : LW'({$urandom(), $urandom(), $urandom(), $urandom()});

    assign bz[g]   = b;
    assign dn[g]   = d;
    assign mr[g]   = m;
    assign tv[g]   = v;
    assign tl[g]   = l;
    assign td[g]   = dat;
    assign trow[g] = 32'(trw);
    assign tcol[g] = 32'(tcl);
    assign mrow[g] = 32'(mrw);
    assign mcol[g] = 32'(mcl);
  end

  always @(posedge clk)
    for (int i = 0; i < 3; i++) if (dn[i] === 1'b1) dcnt[i] <= dcnt[i] + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input int w, input string tag);
    check({tag, " busy"}, 64'(bz[w]), 64'(0));
    check({tag, " done"}, 64'(dn[w]), 64'(0));
    check({tag, " mem_rd"}, 64'(mr[w]), 64'(0));
    check({tag, " mem_row"}, 64'(mrow[w]), 64'(0));
    check({tag, " mem_col"}, 64'(mcol[w]), 64'(0));
    check({tag, " tile_valid"}, 64'(tv[w]), 64'(0));
    check({tag, " tile_last"}, 64'(tl[w]), 64'(0));
    check({tag, " tile_row"}, 64'(trow[w]), 64'(0));
    check({tag, " tile_col"}, 64'(tcol[w]), 64'(0));
    check_data({tag, " tile_data"}, td[w], '0);
  endtask

  task automatic wait_valid(input int w, output bit ok, output int vcyc);
    int n;
    n = 0;
    while (tv[w] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    ok   = (tv[w] === 1'b1);
    vcyc = cyc;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tile_valid timeout dut%0d: got 0 expected 1", w);
    end
  endtask

  // Consume one tile: check it, optionally stall for 'hold' cycles, then handshake.
  task automatic take_tile(input int w, input int unsigned er, input int unsigned ec,
                           input bit el, input int unsigned hold, input string tag,
                           output bit ok, output int vcyc);
    logic [DW-1:0] d0;
    rdy[w] = (hold == 0);
    wait_valid(w, ok, vcyc);
    if (!ok) return;
    check({tag, " pos"}, {trow[w], tcol[w]}, {er, ec});
    check({tag, " last"}, 64'(tl[w]), 64'(el));
    check_data({tag, " data"}, td[w], tile_gold(er, ec));
    d0 = td[w];
    for (int unsigned i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, 64'(tv[w]), 64'(1));
      check({tag, " hold pos"}, {trow[w], tcol[w]}, {er, ec});
      check_data({tag, " hold data"}, td[w], d0);
    end
    rdy[w] = 1'b1;
    tick();
  endtask

  vec_t v3a[6];
  vec_t v3b[12];

  initial begin
    bit          ok;
    int          vcyc, t0, idx, dref;
    logic [DW-1:0] dsave;

    v3a = '{'{0, 0, 0, 1'b0}, '{2, 0, 12, 1'b0}, '{0, 0, 24, 1'b0},
            '{0, 3, 0, 1'b0}, '{3, 3, 12, 1'b0}, '{0, 3, 24, 1'b1}};
    v3b = '{'{0, 0, 0, 1'b0}, '{0, 0, 12, 1'b0}, '{1, 0, 24, 1'b0}, '{0, 0, 26, 1'b0},
            '{0, 3, 0, 1'b0}, '{2, 3, 12, 1'b0}, '{0, 3, 24, 1'b0}, '{0, 3, 26, 1'b0},
            '{0, 5, 0, 1'b0}, '{0, 5, 12, 1'b0}, '{1, 5, 24, 1'b0}, '{0, 5, 26, 1'b1}};

    for (int i = 0; i < 3; i++) begin
      st[i]  = 1'b0;
      rdy[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) check_zero(i, "reset");
    rst = 1'b0;
    tick();

    // Start latency, then the full default frame with ready held high.
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    t0 = cyc;
    for (int unsigned i = 0; i < 7; i++) begin
      check("lat mem_rd", 64'(mr[0]), 64'(i < 5));
      if (i < 5) check("lat mem_addr", {mrow[0], mcol[0]}, {i, 32'd0});
      check("lat tile_valid", 64'(tv[0]), 64'(i == 6));
      if (i < 6) tick();
    end
    ok  = 1'b1;
    idx = 0;
    for (int unsigned r = 0; r <= 477 && ok; r += 3)
      for (int unsigned c = 0; c <= 624 && ok; c += 12) begin
        take_tile(0, r, c, (r == 477 && c == 624), 0, "T1", ok, vcyc);
        if (idx == 0) check("T1 tile0 valid cycle", 64'(vcyc - t0), 64'(6));
        if (idx == 1) check("T1 tile1 valid cycle", 64'(vcyc - t0), 64'(13));
        idx++;
      end
    check("T1 tile count", 64'(idx), 64'(8480));
    check("T1 done", 64'(dn[0]), 64'(1));
    check("T1 busy in done", 64'(bz[0]), 64'(0));
    tick();
    check("T1 done pulse", 64'(dn[0]), 64'(0));

    // Small frame, edges dropped; start held high through busy and the done cycle.
    dref  = dcnt[1];
    st[1] = 1'b1;
    tick();
    ok = 1'b1;
    for (int unsigned i = 0; i < 6 && ok; i++)
      take_tile(1, v3a[i].row, v3a[i].col, v3a[i].last, v3a[i].hold, "T3a", ok, vcyc);
    check("T5 done", 64'(dn[1]), 64'(1));
    tick();
    st[1] = 1'b0;
    check("T5 no restart busy", 64'(bz[1]), 64'(0));
    check("T5 no restart mem_rd", 64'(mr[1]), 64'(0));
    repeat (10) tick();
    check("T5 idle", 64'(bz[1]), 64'(0));
    check("T5 done count", 64'(dcnt[1] - dref), 64'(1));

    // Small frame with edge clamping.
    st[2] = 1'b1;
    tick();
    st[2] = 1'b0;
    ok = 1'b1;
    for (int unsigned i = 0; i < 12 && ok; i++)
      take_tile(2, v3b[i].row, v3b[i].col, v3b[i].last, v3b[i].hold, "T3b", ok, vcyc);
    check("T3b done", 64'(dn[2]), 64'(1));
    tick();

    // Backpressure on the first tile.
    rdy[0] = 1'b0;
    st[0]  = 1'b1;
    tick();
    st[0] = 1'b0;
    wait_valid(0, ok, vcyc);
    if (ok) begin
      check("T2 pos", {trow[0], tcol[0]}, {32'd0, 32'd0});
      dsave = td[0];
      check_data("T2 data", dsave, tile_gold(0, 0));
      for (int i = 0; i < 10; i++) begin
        tick();
        check("T2 held valid", 64'(tv[0]), 64'(1));
        check("T2 held pos", {trow[0], tcol[0]}, {32'd0, 32'd0});
        check_data("T2 held data", td[0], dsave);
      end
      rdy[0] = 1'b1;
      tick();
      check("T2 next fetch", {31'd0, mr[0], mrow[0]}, {31'd0, 1'b1, 32'd0});
      check("T2 next col", 64'(mcol[0]), 64'(12));
      check("T2 valid dropped", 64'(tv[0]), 64'(0));
    end

    // Reset during the fetch of tile 5.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    ok = 1'b1;
    for (int unsigned i = 0; i < 5 && ok; i++)
      take_tile(0, 0, i * 12, 1'b0, 0, "T4 pre", ok, vcyc);
    tick();
    check("T4 in fetch", {31'd0, mr[0], mrow[0]}, {31'd0, 1'b1, 32'd1});
    check("T4 fetch col", 64'(mcol[0]), 64'(60));
    dref = dcnt[0];
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    check_zero(0, "T4");
    repeat (20) tick();
    check("T4 no done", 64'(dcnt[0] - dref), 64'(0));
    check("T4 idle", 64'(bz[0]), 64'(0));
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    check("T4 restart addr", {mrow[0], mcol[0]}, {32'd0, 32'd0});
    check("T4 restart rd", 64'(mr[0]), 64'(1));
    take_tile(0, 0, 0, 1'b0, 0, "T4 restart", ok, vcyc);
    rst = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
